// File: rtl/mario_jump_mover.sv
// Vertical motion for Mario: jump rise, apex hang, gravity fall and landing on solid tiles.
// Optional build macro MARIO_VARIABLE_JUMP_EN lets an early jump release cut the rise short.
module mario_jump_mover #(
   parameter int BDR             = 0,
   parameter int SKY             = 1,
   parameter int BLK             = 2,
   parameter int GND             = 3,
   parameter int CHARACTER_WIDTH = 42,
   parameter int SCREEN_HEIGHT   = 480,
   parameter int BLOCK_WIDTH     = 40,
   parameter int JUMP_HEIGHT     = 120,
   parameter int HANG_TICKS      = 4,
   parameter int START_Y         = 358
) (
   input  logic                    movement_clock,
   input  logic                    reset,
   input  logic                    jump,
   input  logic [11:0][16:0][7:0]  background,
   input  logic [31:0]             mario_x,
   output logic [31:0]             mario_y,
   output logic                    airborne,
   output logic                    landed
);

   localparam int         HANG_LOAD = (HANG_TICKS < 1) ? 0 : HANG_TICKS - 1;
   localparam logic [7:0] BDR_C     = BDR[7:0];
   localparam logic [7:0] SKY_C     = SKY[7:0];
   localparam logic [7:0] BLK_C     = BLK[7:0];
   localparam logic [7:0] GND_C     = GND[7:0];

   typedef enum logic [1:0] {
      GROUNDED = 2'd0,
      RISING   = 2'd1,
      APEX     = 2'd2,
      FALLING  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] mario_y_q, mario_y_d;
   logic [31:0] rise_cnt_q, rise_cnt_d;
   logic [31:0] hang_cnt_q, hang_cnt_d;
   logic        airborne_q, airborne_d;
   logic        landed_q, landed_d;
   logic        jump_q;
   logic        armed_q;

   logic [31:0] col_l, col_r, foot_y, foot_row, head_row;
   logic        floor_solid, head_blocked, jump_rise, early_release;

   // Out-of-map rows/columns read as open space rather than indexing past the array.
   function automatic logic tile_solid(input logic [11:0][16:0][7:0] map,
                                       input logic [31:0] row,
                                       input logic [31:0] col);
      logic [7:0] code;
      code       = 8'd0;
      tile_solid = 1'b0;
      if (row < 32'd12 && col < 32'd17) begin
         code       = map[row[3:0]][col[4:0]];
         tile_solid = (code == BLK_C || code == GND_C) && code != BDR_C && code != SKY_C;
      end
   endfunction

   always_comb begin
      col_l        = mario_x / BLOCK_WIDTH;
      col_r        = (mario_x + CHARACTER_WIDTH - 1) / BLOCK_WIDTH;
      foot_y       = mario_y_q + CHARACTER_WIDTH;
      foot_row     = foot_y / BLOCK_WIDTH;
      head_row     = 32'd0;
      floor_solid  = 1'b0;
      head_blocked = 1'b0;
      if (foot_y >= SCREEN_HEIGHT) begin
         floor_solid = 1'b1;
      end else begin
         floor_solid = tile_solid(background, foot_row, col_l) ||
                       tile_solid(background, foot_row, col_r);
      end
      if (mario_y_q == 32'd0) begin
         head_blocked = 1'b1;
      end else begin
         head_row     = (mario_y_q - 1) / BLOCK_WIDTH;
         head_blocked = tile_solid(background, head_row, col_l) ||
                        tile_solid(background, head_row, col_r);
      end
   end

   // armed_q stays low while a press held through reset is still down.
   assign jump_rise = jump & ~jump_q & armed_q;

`ifdef MARIO_VARIABLE_JUMP_EN
   assign early_release = ~jump;
`else
   assign early_release = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      mario_y_d  = mario_y_q;
      rise_cnt_d = rise_cnt_q;
      hang_cnt_d = hang_cnt_q;
      landed_d   = 1'b0;
      case (state_q)
         GROUNDED: begin
            if (!floor_solid) begin
               state_d = FALLING;
            end else if (jump_rise && !head_blocked) begin
               state_d    = RISING;
               rise_cnt_d = 32'd0;
            end
         end
         RISING: begin
            if (head_blocked || rise_cnt_q == JUMP_HEIGHT || early_release) begin
               state_d    = APEX;
               hang_cnt_d = HANG_LOAD;
            end else begin
               mario_y_d  = mario_y_q - 1;
               rise_cnt_d = rise_cnt_q + 1;
            end
         end
         APEX: begin
            if (hang_cnt_q == 32'd0) begin
               state_d = FALLING;
            end else begin
               hang_cnt_d = hang_cnt_q - 1;
            end
         end
         FALLING: begin
            if (floor_solid) begin
               state_d  = GROUNDED;
               landed_d = 1'b1;
            end else begin
               mario_y_d = mario_y_q + 1;
            end
         end
         default: state_d = GROUNDED;
      endcase
      airborne_d = (state_d != GROUNDED);
   end

   always_ff @(posedge movement_clock) begin
      if (reset) begin
         state_q    <= GROUNDED;
         mario_y_q  <= START_Y;
         rise_cnt_q <= 32'd0;
         hang_cnt_q <= 32'd0;
         airborne_q <= 1'b0;
         landed_q   <= 1'b0;
         jump_q     <= 1'b0;
         armed_q    <= ~jump;
      end else begin
         state_q    <= state_d;
         mario_y_q  <= mario_y_d;
         rise_cnt_q <= rise_cnt_d;
         hang_cnt_q <= hang_cnt_d;
         airborne_q <= airborne_d;
         landed_q   <= landed_d;
         jump_q     <= jump;
         armed_q    <= armed_q | ~jump;
      end
   end

   assign mario_y  = mario_y_q;
   assign airborne = airborne_q;
   assign landed   = landed_q;

endmodule

// File: tb/tb_mario_jump_mover.sv
// Scoreboard bench for mario_jump_mover: each scenario queues the expected per-edge
// trajectory derived from the jump timing rules, then pops and compares one entry per edge.
module tb_mario_jump_mover;

   localparam int SKY = 1;
   localparam int BLK = 2;
   localparam int GND = 3;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   jump;
   logic [11:0][16:0][7:0] background;
   logic [31:0]            mario_x;
   logic [31:0]            mario_y;
   logic                   airborne;
   logic                   landed;

   typedef struct packed {
      logic [31:0] y;
      logic        air;
      logic        land;
   } exp_t;

   exp_t exp_q[$];
   int   n_compared   = 0;
   int   n_mismatched = 0;

   always #5 clk = ~clk;

   mario_jump_mover dut (
      .movement_clock(clk),
      .reset         (reset),
      .jump          (jump),
      .background    (background),
      .mario_x       (mario_x),
      .mario_y       (mario_y),
      .airborne      (airborne),
      .landed        (landed)
   );

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic push(input int y, input logic air, input logic land);
      exp_t e;
      e.y    = 32'(y);
      e.air  = air;
      e.land = land;
      exp_q.push_back(e);
   endtask

   // Full flat-ground jump from y=358 topping out at apex, then landing back at 358.
   task automatic push_jump(input int apex);
      push(358, 1'b1, 1'b0);
      for (int y = 357; y >= apex; y--) push(y, 1'b1, 1'b0);
      repeat (5) push(apex, 1'b1, 1'b0);
      for (int y = apex + 1; y <= 358; y++) push(y, 1'b1, 1'b0);
      push(358, 1'b0, 1'b1);
      push(358, 1'b0, 1'b0);
   endtask

   task automatic drive_edge(input logic j);
      jump = j;
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t observed();
      exp_t o;
      o.y    = mario_y;
      o.air  = airborne;
      o.land = landed;
      return o;
   endfunction

   task automatic init_map();
      for (int r = 0; r < 12; r++)
         for (int c = 0; c < 17; c++)
            background[r][c] = (r >= 10) ? 8'(GND) : 8'(SKY);
   endtask

   task automatic test_reset();
      int   k = 0;
      exp_t e, got;
      repeat (14) push(358, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         reset = (k < 2);
         drive_edge(k < 12);
         e   = exp_q.pop_front();
         got = observed();
         n_compared++;
         if (got !== e) begin
            n_mismatched++;
            $display("[TB] FAIL reset edge %0d: got y=%0d air=%b landed=%b, want y=%0d air=%b landed=%b",
                     k, got.y, got.air, got.land, e.y, e.air, e.land);
         end
         k++;
      end
   endtask

   task automatic test_full_jump();
      int   k = 0;
      exp_t e, got;
      push_jump(238);
      while (exp_q.size() > 0) begin
         drive_edge(k < 1);
         e   = exp_q.pop_front();
         got = observed();
         n_compared++;
         if (got !== e) begin
            n_mismatched++;
            $display("[TB] FAIL full_jump edge %0d: got y=%0d air=%b landed=%b, want y=%0d air=%b landed=%b",
                     k, got.y, got.air, got.land, e.y, e.air, e.land);
         end
         k++;
      end
   endtask

   task automatic test_head_block();
      int   k = 0;
      exp_t e, got;
      background[7][2] = 8'(BLK);
      push_jump(320);
      while (exp_q.size() > 0) begin
         drive_edge(k < 1);
         e   = exp_q.pop_front();
         got = observed();
         n_compared++;
         if (got !== e) begin
            n_mismatched++;
            $display("[TB] FAIL head_block edge %0d: got y=%0d air=%b landed=%b, want y=%0d air=%b landed=%b",
                     k, got.y, got.air, got.land, e.y, e.air, e.land);
         end
         k++;
      end
      background[7][2] = 8'(SKY);
   endtask

   task automatic test_held_jump();
      int   k = 0;
      exp_t e, got;
      push_jump(238);
      while (exp_q.size() < 600) push(358, 1'b0, 1'b0);
      push(358, 1'b0, 1'b0);
      push_jump(238);
      while (exp_q.size() > 0) begin
         drive_edge(k < 600 || k == 601);
         e   = exp_q.pop_front();
         got = observed();
         n_compared++;
         if (got !== e) begin
            n_mismatched++;
            $display("[TB] FAIL held_jump edge %0d: got y=%0d air=%b landed=%b, want y=%0d air=%b landed=%b",
                     k, got.y, got.air, got.land, e.y, e.air, e.land);
         end
         k++;
      end
   endtask

   task automatic test_variable_jump();
      int   k = 0;
      exp_t e, got;
`ifdef MARIO_VARIABLE_JUMP_EN
      push_jump(328);
`else
      push_jump(238);
`endif
      while (exp_q.size() > 0) begin
         drive_edge(k < 31);
         e   = exp_q.pop_front();
         got = observed();
         n_compared++;
         if (got !== e) begin
            n_mismatched++;
            $display("[TB] FAIL variable_jump edge %0d: got y=%0d air=%b landed=%b, want y=%0d air=%b landed=%b",
                     k, got.y, got.air, got.land, e.y, e.air, e.land);
         end
         k++;
      end
   endtask

   task automatic test_reset_mid_fall();
      int   k = 0;
      exp_t e, got;
      push(358, 1'b1, 1'b0);
      for (int y = 357; y >= 238; y--) push(y, 1'b1, 1'b0);
      repeat (5) push(238, 1'b1, 1'b0);
      for (int y = 239; y <= 248; y++) push(y, 1'b1, 1'b0);
      repeat (3) push(358, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         reset = (k == 136);
         drive_edge(k < 1);
         e   = exp_q.pop_front();
         got = observed();
         n_compared++;
         if (got !== e) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mid_fall edge %0d: got y=%0d air=%b landed=%b, want y=%0d air=%b landed=%b",
                     k, got.y, got.air, got.land, e.y, e.air, e.land);
         end
         k++;
      end
      reset = 1'b0;
   endtask

   task automatic test_fall_off_ledge();
      int   k = 0;
      exp_t e, got;
      for (int r = 10; r < 12; r++)
         for (int c = 2; c < 4; c++)
            background[r][c] = 8'(SKY);
      push(358, 1'b1, 1'b0);
      for (int y = 359; y <= 438; y++) push(y, 1'b1, 1'b0);
      push(438, 1'b0, 1'b1);
      push(438, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         drive_edge(1'b0);
         e   = exp_q.pop_front();
         got = observed();
         n_compared++;
         if (got !== e) begin
            n_mismatched++;
            $display("[TB] FAIL fall_off_ledge edge %0d: got y=%0d air=%b landed=%b, want y=%0d air=%b landed=%b",
                     k, got.y, got.air, got.land, e.y, e.air, e.land);
         end
         k++;
      end
   endtask

   initial begin
      reset   = 1'b1;
      jump    = 1'b1;
      mario_x = 32'd100;
      init_map();
      test_reset();
      test_full_jump();
      test_head_block();
      test_held_jump();
      test_variable_jump();
      test_reset_mid_fall();
      test_fall_off_ledge();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
